// File: rtl/uart_mmio_ctrl.sv
// uart_mmio_ctrl: CPU register front-end for the UART serializers.
// Buffers TX/RX bytes in FIFOs, sequences the transmitter and raises a level irq.
module uart_mmio_ctrl #(
  parameter int unsigned DEPTH        = 16,
  parameter int unsigned PAYLOAD_BITS = 8,
  parameter logic [63:0] BASE_ADDR    = 64'h5000_0000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [63:0]             bus_addr,
  input  logic [31:0]             bus_wdata,
  input  logic                    bus_wen,
  input  logic                    bus_ren,
  output logic [31:0]             bus_rdata,
  input  logic                    uart_tx_busy,
  output logic                    uart_tx_en,
  output logic [PAYLOAD_BITS-1:0] uart_tx_data,
  input  logic                    uart_rx_valid,
  input  logic [PAYLOAD_BITS-1:0] uart_rx_data,
  input  logic                    uart_rx_break,
  output logic                    irq
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [63:0] DATA_ADDR   = BASE_ADDR;
  localparam logic [63:0] STATUS_ADDR = BASE_ADDR + 64'h4;
  localparam logic [63:0] CTRL_ADDR   = BASE_ADDR + 64'h8;

  typedef enum logic [1:0] {IDLE, WAIT_BUSY, WAIT_DONE} state_t;

  state_t state, state_next;
  logic [1:0] wait_cnt;
  logic       tx_pop_c;

  logic [PAYLOAD_BITS-1:0] tx_mem [DEPTH];
  logic [PAYLOAD_BITS-1:0] rx_mem [DEPTH];
  logic [PW-1:0] tx_wp, tx_rp, rx_wp, rx_rp;
  logic [CW-1:0] tx_cnt, rx_cnt;
  logic rx_ie, tx_ie, rx_ovr, tx_ovf, brk;

  logic sel_data, sel_status, sel_ctrl;
  logic wr_data, wr_ctrl, rd_data;
  logic tx_full, tx_empty, rx_full, rx_empty, tx_idle;
  logic tx_push, tx_flush, rx_push, rx_pop, rx_flush;
  logic tx_ovf_set, rx_ovr_set;
  logic [PAYLOAD_BITS-1:0] rx_head;
  logic unused_wdata;

  assign unused_wdata = ^bus_wdata[31:PAYLOAD_BITS];

  // Address decode and FIFO status
  assign sel_data   = (bus_addr == DATA_ADDR);
  assign sel_status = (bus_addr == STATUS_ADDR);
  assign sel_ctrl   = (bus_addr == CTRL_ADDR);
  assign wr_data    = bus_wen & sel_data;
  assign wr_ctrl    = bus_wen & sel_ctrl;
  assign rd_data    = bus_ren & sel_data;

  assign tx_full  = (tx_cnt == CW'(DEPTH));
  assign tx_empty = (tx_cnt == '0);
  assign rx_full  = (rx_cnt == CW'(DEPTH));
  assign rx_empty = (rx_cnt == '0);
  assign tx_idle  = (state == IDLE) & tx_empty;
  assign rx_head  = rx_mem[rx_rp];

  // Flush wins over pushes; a full RX FIFO still accepts when popped the same cycle
  assign tx_flush   = wr_ctrl & bus_wdata[2];
  assign rx_flush   = wr_ctrl & bus_wdata[3];
  assign tx_push    = wr_data & ~tx_full & ~tx_flush;
  assign tx_ovf_set = wr_data & tx_full;
  assign rx_pop     = rd_data & ~rx_empty;
  assign rx_push    = uart_rx_valid & (~rx_full | rx_pop) & ~rx_flush;
  assign rx_ovr_set = uart_rx_valid & rx_full & ~rx_pop;

  // TX FIFO storage
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wp] <= bus_wdata[PAYLOAD_BITS-1:0];
  end

  // RX FIFO storage
  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wp] <= uart_rx_data;
  end

  // TX FIFO pointers and count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_wp  <= '0;
      tx_rp  <= '0;
      tx_cnt <= '0;
    end else if (tx_flush) begin
      tx_wp  <= '0;
      tx_rp  <= '0;
      tx_cnt <= '0;
    end else begin
      if (tx_push)  tx_wp <= tx_wp + PW'(1);
      if (tx_pop_c) tx_rp <= tx_rp + PW'(1);
      tx_cnt <= tx_cnt + CW'(tx_push) - CW'(tx_pop_c);
    end
  end

  // RX FIFO pointers and count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_wp  <= '0;
      rx_rp  <= '0;
      rx_cnt <= '0;
    end else if (rx_flush) begin
      rx_wp  <= '0;
      rx_rp  <= '0;
      rx_cnt <= '0;
    end else begin
      if (rx_push) rx_wp <= rx_wp + PW'(1);
      if (rx_pop)  rx_rp <= rx_rp + PW'(1);
      rx_cnt <= rx_cnt + CW'(rx_push) - CW'(rx_pop);
    end
  end

  // Control bits, sticky flags (set beats same-cycle clear) and registered irq
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_ie  <= 1'b0;
      tx_ie  <= 1'b0;
      rx_ovr <= 1'b0;
      tx_ovf <= 1'b0;
      brk    <= 1'b0;
      irq    <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        rx_ie <= bus_wdata[0];
        tx_ie <= bus_wdata[1];
      end
      rx_ovr <= rx_ovr_set    | (rx_ovr & ~(wr_ctrl & bus_wdata[4]));
      tx_ovf <= tx_ovf_set    | (tx_ovf & ~(wr_ctrl & bus_wdata[5]));
      brk    <= uart_rx_break | (brk    & ~(wr_ctrl & bus_wdata[6]));
      irq    <= (rx_ie & ~rx_empty) | (tx_ie & tx_idle);
    end
  end

  // TX FSM state register and lost-start timer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      wait_cnt <= '0;
    end else begin
      state    <= state_next;
      wait_cnt <= (state == WAIT_BUSY) ? wait_cnt + 2'd1 : 2'd0;
    end
  end

  // TX FSM next state
  always_comb begin
    state_next = state;
    case (state)
      IDLE:      if (!tx_empty && !uart_tx_busy) state_next = WAIT_BUSY;
      WAIT_BUSY: if (uart_tx_busy) state_next = WAIT_DONE;
                 else if (wait_cnt == 2'd3) state_next = IDLE;
      WAIT_DONE: if (!uart_tx_busy) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  // TX FSM outputs: launch decision pops the FIFO head
  always_comb begin
    tx_pop_c = 1'b0;
    if (state == IDLE && !tx_empty && !uart_tx_busy) tx_pop_c = 1'b1;
  end

  // Registered transmitter strobe and data (data holds between launches)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      uart_tx_en   <= 1'b0;
      uart_tx_data <= '0;
    end else begin
      uart_tx_en <= tx_pop_c;
      if (tx_pop_c) uart_tx_data <= tx_mem[tx_rp];
    end
  end

  // Register read mux
  always_comb begin
    bus_rdata = '0;
    if (sel_data) begin
      if (!rx_empty) begin
        bus_rdata[31]                 = 1'b1;
        bus_rdata[PAYLOAD_BITS-1:0]   = rx_head;
      end
    end else if (sel_status) begin
      bus_rdata[0]     = tx_full;
      bus_rdata[1]     = tx_empty;
      bus_rdata[2]     = rx_full;
      bus_rdata[3]     = rx_empty;
      bus_rdata[4]     = rx_ovr;
      bus_rdata[5]     = tx_ovf;
      bus_rdata[6]     = brk;
      bus_rdata[7]     = tx_idle;
      bus_rdata[15:8]  = 8'(rx_cnt);
      bus_rdata[23:16] = 8'(tx_cnt);
    end else if (sel_ctrl) begin
      bus_rdata[1:0] = {tx_ie, rx_ie};
    end
  end

endmodule
